// File: rtl/dwsep_conv2d_sequencer.sv
// Loop controller for a depthwise-separable 2D convolution datapath.
// For every output pixel (oy, ox) it issues the depthwise MACs (c, ky, kx)
// and then the pointwise MACs (oc, ic) as registered commands on a
// valid/ready port. The counters always name the command currently on the
// port; the next command is derived from their advanced values, so
// back-to-back beats need no bubble.
module dwsep_conv2d_sequencer #(
    parameter int IN_CH  = 2,
    parameter int OUT_CH = 3,
    parameter int K      = 3,
    parameter int IMG_H  = 5,
    parameter int IMG_W  = 5,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_phase,
    output logic [ADDR_W-1:0] cmd_in_addr,
    output logic [ADDR_W-1:0] cmd_w_addr,
    output logic [ADDR_W-1:0] cmd_out_addr,
    output logic              cmd_first,
    output logic              cmd_last
);
    localparam int OH = IMG_H - K + 1;
    localparam int OW = IMG_W - K + 1;
    // Wide enough for any single loop bound.
    localparam int CW = $clog2(IN_CH + OUT_CH + K + IMG_H + IMG_W);

    typedef enum logic [2:0] {S_IDLE, S_DW, S_PW, S_WRAP, S_DONE} state_t;
    state_t state;

    logic [CW-1:0] oy, ox, c, ky, kx, oc, ic;
    logic [CW-1:0] n_oy, n_ox, n_c, n_ky, n_kx, n_oc, n_ic;
    logic [CW-1:0] l_oy, l_ox, l_c, l_ky, l_kx, l_oc, l_ic;
    logic          n_pw, l_pw, last_beat, beat;
    logic [ADDR_W-1:0] l_in, l_w, l_out;
    logic          l_first, l_last;

    assign beat = cmd_valid & cmd_ready;

    // Advance the nested loop by one beat: kx->ky->c then PW, ic->oc then next pixel.
    always_comb begin
        n_oy = oy; n_ox = ox; n_c = c; n_ky = ky; n_kx = kx; n_oc = oc; n_ic = ic;
        n_pw = (state == S_PW);
        last_beat = 1'b0;
        if (state != S_PW) begin
            if (kx != CW'(K-1)) n_kx = kx + CW'(1);
            else begin
                n_kx = '0;
                if (ky != CW'(K-1)) n_ky = ky + CW'(1);
                else begin
                    n_ky = '0;
                    if (c != CW'(IN_CH-1)) n_c = c + CW'(1);
                    else begin
                        n_c  = '0;
                        n_pw = 1'b1;
                    end
                end
            end
        end else begin
            if (ic != CW'(IN_CH-1)) n_ic = ic + CW'(1);
            else begin
                n_ic = '0;
                if (oc != CW'(OUT_CH-1)) n_oc = oc + CW'(1);
                else begin
                    n_oc = '0;
                    n_pw = 1'b0;
                    if (ox != CW'(OW-1)) n_ox = ox + CW'(1);
                    else begin
                        n_ox = '0;
                        if (oy != CW'(OH-1)) n_oy = oy + CW'(1);
                        else begin
                            n_oy = '0;
                            last_beat = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Fields of the command to load: the advanced counters after a beat, else
    // the current ones (first load of a frame, counters all zero).
    always_comb begin
        l_oy = beat ? n_oy : oy;
        l_ox = beat ? n_ox : ox;
        l_c  = beat ? n_c  : c;
        l_ky = beat ? n_ky : ky;
        l_kx = beat ? n_kx : kx;
        l_oc = beat ? n_oc : oc;
        l_ic = beat ? n_ic : ic;
        l_pw = beat ? n_pw : (state == S_PW);
        if (!l_pw) begin
            l_in    = ADDR_W'(l_c) * ADDR_W'(IMG_H*IMG_W)
                    + (ADDR_W'(l_oy) + ADDR_W'(l_ky)) * ADDR_W'(IMG_W)
                    + ADDR_W'(l_ox) + ADDR_W'(l_kx);
            l_w     = ADDR_W'(l_c) * ADDR_W'(K*K) + ADDR_W'(l_ky) * ADDR_W'(K) + ADDR_W'(l_kx);
            l_out   = ADDR_W'(l_c);
            l_first = (l_ky == '0) && (l_kx == '0);
            l_last  = (l_ky == CW'(K-1)) && (l_kx == CW'(K-1));
        end else begin
            l_in    = ADDR_W'(l_ic);
            l_w     = ADDR_W'(IN_CH*K*K) + ADDR_W'(l_oc) * ADDR_W'(IN_CH) + ADDR_W'(l_ic);
            l_out   = ADDR_W'(l_oc) * ADDR_W'(OH*OW) + ADDR_W'(l_oy) * ADDR_W'(OW) + ADDR_W'(l_ox);
            l_first = (l_ic == '0);
            l_last  = (l_ic == CW'(IN_CH-1));
        end
    end

    // Frame FSM, loop counters and registered command/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            {oy, ox, c, ky, kx, oc, ic} <= '0;
            busy <= 1'b0; done <= 1'b0; cmd_valid <= 1'b0;
            cmd_phase <= 1'b0; cmd_first <= 1'b0; cmd_last <= 1'b0;
            cmd_in_addr <= '0; cmd_w_addr <= '0; cmd_out_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_DW;
                        busy  <= 1'b1;
                        {oy, ox, c, ky, kx, oc, ic} <= '0;
                    end
                end
                S_DW, S_PW: begin
                    if (!cmd_valid || cmd_ready) begin
                        if (beat) begin
                            {oy, ox, c, ky, kx, oc, ic} <= {n_oy, n_ox, n_c, n_ky, n_kx, n_oc, n_ic};
                        end
                        if (beat && last_beat) begin
                            cmd_valid <= 1'b0;
                            state     <= S_WRAP;
                        end else begin
                            cmd_valid    <= 1'b1;
                            state        <= l_pw ? S_PW : S_DW;
                            cmd_phase    <= l_pw;
                            cmd_in_addr  <= l_in;
                            cmd_w_addr   <= l_w;
                            cmd_out_addr <= l_out;
                            cmd_first    <= l_first;
                            cmd_last     <= l_last;
                        end
                    end
                end
                // One quiet cycle after the final beat so done lands in its own cycle.
                S_WRAP: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dwsep_conv2d_sequencer.sv
// Directed bench for dwsep_conv2d_sequencer at default parameters
// (OH=OW=3, 24 beats per pixel, 216 beats per frame).
module tb_dwsep_conv2d_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, cmd_valid, cmd_phase, cmd_first, cmd_last;
    logic        cmd_ready;
    logic [15:0] cmd_in_addr, cmd_w_addr, cmd_out_addr;

    dwsep_conv2d_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_phase(cmd_phase),
        .cmd_in_addr(cmd_in_addr), .cmd_w_addr(cmd_w_addr), .cmd_out_addr(cmd_out_addr),
        .cmd_first(cmd_first), .cmd_last(cmd_last)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected command of beat b, packed as {phase,first,last,in,w,out}.
    function automatic logic [63:0] model(input int b);
        int pix, r, oy, ox, c, ky, kx, oc, ic, p;
        logic ph, f, l;
        int ia, wa, oa;
        pix = b / 24; r = b % 24; oy = pix / 3; ox = pix % 3;
        if (r < 18) begin
            c = r / 9; ky = (r % 9) / 3; kx = r % 3;
            ph = 1'b0; ia = c*25 + (oy+ky)*5 + ox + kx; wa = c*9 + ky*3 + kx; oa = c;
            f = (ky == 0 && kx == 0); l = (ky == 2 && kx == 2);
        end else begin
            p = r - 18; oc = p / 2; ic = p % 2;
            ph = 1'b1; ia = ic; wa = 18 + oc*2 + ic; oa = oc*9 + oy*3 + ox;
            f = (ic == 0); l = (ic == 1);
        end
        return {13'd0, ph, f, l, ia[15:0], wa[15:0], oa[15:0]};
    endfunction

    function automatic logic [63:0] dut_cmd();
        return {13'd0, cmd_phase, cmd_first, cmd_last, cmd_in_addr, cmd_w_addr, cmd_out_addr};
    endfunction

    // Ready driver: always-ready or 50% random backpressure.
    bit rnd_ready = 1'b0;
    initial begin
        cmd_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            cmd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: per-beat model compare, hold-while-stalled, gaps, done pulses.
    int beat_idx = 0, gaps = 0, done_cnt = 0, done_cyc = 0;
    logic [63:0] cap [0:215];
    logic [63:0] snap;
    bit prev_stall = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n || (start && !busy)) begin
                beat_idx = 0; gaps = 0; done_cnt = 0; prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 64'(cmd_valid), 64'd1);
                    chk("hold_cmd", dut_cmd(), snap);
                end
                if (beat_idx > 0 && beat_idx < 216 && !cmd_valid) gaps++;
                if (cmd_valid && cmd_ready) begin
                    if (beat_idx < 216) begin
                        cap[beat_idx] = dut_cmd();
                        chk("beat", dut_cmd(), model(beat_idx));
                    end
                    beat_idx++;
                end
                prev_stall = cmd_valid && !cmd_ready;
                snap = dut_cmd();
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic pulse_start(output int s_cyc);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        s_cyc = cyc;
    endtask

    // One frame: start, optional re-start at beat restart_at, then full-frame checks.
    task automatic run_frame(input int restart_at, input int exp_lat);
        int s_cyc;
        bit restarted = 1'b0;
        bit ok = 1'b0;
        pulse_start(s_cyc);
        @(negedge clk);
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("valid_latency", 64'(cmd_valid), 64'd0);
        @(negedge clk);
        chk("first_valid", 64'(cmd_valid), 64'd1);
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk); #2;
            if (restart_at >= 0 && !restarted && beat_idx >= restart_at) begin
                start = 1'b1; restarted = 1'b1;
                @(posedge clk); #2 start = 1'b0;
            end
            if (done_cnt > 0) begin ok = 1'b1; break; end
        end
        chk("done_seen", 64'(ok), 64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("beats", 64'(beat_idx), 64'd216);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("gaps", 64'(gaps), 64'd0);
        chk("busy_end", 64'(busy), 64'd0);
        chk("valid_end", 64'(cmd_valid), 64'd0);
        if (exp_lat >= 0) chk("start_to_done", 64'(done_cyc - s_cyc), 64'(exp_lat));
    endtask

    initial begin
        // Reset for 2 cycles: everything low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(cmd_valid), 64'd0);
        chk("rst_addrs", {16'd0, cmd_in_addr, cmd_w_addr, cmd_out_addr}, 64'd0);
        rst_n = 1'b1;

        // Full-rate frame and hand-picked beats.
        run_frame(-1, 218);
        chk("b0",  cap[0],  {13'd0, 1'b0, 1'b1, 1'b0, 16'd0,  16'd0,  16'd0});
        chk("b8",  cap[8],  {13'd0, 1'b0, 1'b0, 1'b1, 16'd12, 16'd8,  16'd0});
        chk("b9",  cap[9],  {13'd0, 1'b0, 1'b1, 1'b0, 16'd25, 16'd9,  16'd1});
        chk("b18", cap[18], {13'd0, 1'b1, 1'b1, 1'b0, 16'd0,  16'd18, 16'd0});
        chk("b23", cap[23], {13'd0, 1'b1, 1'b0, 1'b1, 16'd1,  16'd23, 16'd18});
        chk("b24", cap[24], {13'd0, 1'b0, 1'b1, 1'b0, 16'd1,  16'd0,  16'd0});
        chk("b215", cap[215], {13'd0, 1'b1, 1'b0, 1'b1, 16'd1, 16'd23, 16'd26});

        // Random backpressure.
        rnd_ready = 1'b1;
        run_frame(-1, -1);
        rnd_ready = 1'b0;

        // start while busy is ignored.
        run_frame(100, 218);

        // Reset mid-frame, then a clean frame from beat 0.
        begin
            int s_cyc;
            pulse_start(s_cyc);
            for (int t = 0; t < 500 && beat_idx < 50; t++) @(posedge clk);
            chk("reached_beat50", 64'(beat_idx >= 50), 64'd1);
            @(posedge clk); #1 rst_n = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("mid_rst_busy", 64'(busy), 64'd0);
            chk("mid_rst_valid", 64'(cmd_valid), 64'd0);
            chk("mid_rst_addrs", {13'd0, cmd_phase, cmd_first, cmd_last, cmd_in_addr, cmd_w_addr, cmd_out_addr}, 64'd0);
            #1 rst_n = 1'b1;
        end
        run_frame(-1, 218);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
